inst_mem: RTL and testbench
===========================

INST_MEM -- requirements
Module: inst_mem

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit instruction words stored.
REQ-002 Parameter WAIT_CYCLES, default 1, extra cycles between request acceptance and response (0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid_i  input  1  fetch request present.
REQ-006 req_addr_i  input  32  byte address of instruction (PC from core fetch stage).
REQ-007 req_ready_o  output  1  block can accept a request this cycle.
REQ-008 resp_valid_o  output  1  response word valid.
REQ-009 resp_ready_i  input  1  requester accepts response this cycle.
REQ-010 resp_inst_o  output  32  fetched instruction.
REQ-011 resp_err_o  output  1  address fault flag for the current response.
REQ-012 wr_en_i  input  1  program-load write strobe.
REQ-013 wr_addr_i  input  32  program-load byte address.
REQ-014 wr_data_i  input  32  program-load data word.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-016 Request accepted on edge where req_valid_i && req_ready_o; req_addr_i latched that edge.
REQ-017 Accept with WAIT_CYCLES=0: IDLE -> RESP; otherwise IDLE -> WAIT, wait counter loaded with WAIT_CYCLES-1.
REQ-018 WAIT: counter decrements each cycle; at 0 -> RESP.
REQ-019 resp_valid_o SHALL rise exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-020 Memory read at the WAIT/IDLE -> RESP transition edge into response register; word index = latched addr[31:2].
REQ-021 Index >= DEPTH: resp_err_o=1, resp_inst_o=32'h00000013 (NOP), no array access.
REQ-022 RESP: resp_valid_o, resp_inst_o, resp_err_o held stable until resp_ready_i=1.
REQ-023 RESP with resp_ready_i=1 -> IDLE; next request accepted no earlier than following cycle (one transaction per WAIT_CYCLES+2 cycles max).
REQ-024 req_valid_i outside IDLE ignored; requester holds request until accepted.
REQ-025 wr_en_i=1 writes wr_data_i to mem[wr_addr_i[31:2]] in any state; index >= DEPTH write discarded silently.
REQ-026 Write and read of same index on same edge: response captures old data (read-before-write).
REQ-027 Wait counter width SHALL be 4 bits; no wrap-around possible within legal WAIT_CYCLES.

Reset
REQ-028 rst=1 asynchronously forces state IDLE, wait counter 0, resp_valid_o=0, resp_inst_o=0, resp_err_o=0.
REQ-029 req_ready_o SHALL be 0 while rst=1 and 1 in first cycle after release.
REQ-030 Reset mid-transaction abandons it; no response produced afterward.
REQ-031 Memory array contents not reset; writes ignored while rst=1.

Configuration
REQ-032 Macro INST_MEM_ALIGN_CHECK_EN defined: request with addr[1:0]!=0 -> resp_err_o=1, resp_inst_o=32'h00000013, same latency as normal read.
REQ-033 Macro undefined: addr[1:0] ignored, misaligned addresses read word addr[31:2] normally, no error.

Verification
REQ-034 Load mem[0]=32'h00500093 via write port, WAIT_CYCLES=1, request addr 0 -> resp_valid_o high 2 cycles after accept, resp_inst_o=32'h00500093, resp_err_o=0.
REQ-035 DEPTH=256, request addr 32'h00000400 -> resp_err_o=1, resp_inst_o=32'h00000013.
REQ-036 Hold resp_ready_i=0 for 5 cycles in RESP -> outputs stable, req_ready_o=0; release -> IDLE next cycle, req_ready_o=1.
REQ-037 Write mem[4]=32'hAAAA0000 on the edge capturing read of addr 32'h10 (old 32'h11111111) -> response 32'h11111111, later read returns 32'hAAAA0000.
REQ-038 Assert rst during WAIT -> resp_valid_o=0 immediately, state IDLE; no response after release.
REQ-039 With INST_MEM_ALIGN_CHECK_EN, request addr 32'h00000002 -> resp_err_o=1, resp_inst_o=32'h00000013; without it, returns mem[0].

Source files
------------

// File: rtl/inst_mem.sv
// Instruction memory with a fixed-latency fetch port and a program-load write port.
// Optional INST_MEM_ALIGN_CHECK_EN flags fetches whose byte address is not word aligned.
module inst_mem #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_inst_o,
  output logic        resp_err_o,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i
);

  localparam logic [31:0] NOP_INST  = 32'h00000013;
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_WAIT   = 2'd1;
  localparam logic [1:0]  ST_RESP   = 2'd2;
  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U   = 32'(DEPTH);
  localparam bit          NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0] mem [DEPTH];

  logic [1:0]  state_reg;
  logic [3:0]  wait_cnt_reg;
  logic [31:0] addr_reg;
  logic [31:0] resp_inst_reg;
  logic        resp_err_reg;

  logic        load_resp;
  logic [31:0] rd_addr;
  logic [29:0] rd_word;
  logic        rd_in_range;
  logic        rd_err;
  logic [29:0] wr_word;
  logic        wr_in_range;

  // The read address comes straight from the port when the response is loaded on the accept edge.
  assign rd_addr     = (state_reg == ST_IDLE) ? req_addr_i : addr_reg;
  assign rd_word     = rd_addr[31:2];
  assign rd_in_range = ({2'b00, rd_word} < DEPTH_U);
  assign wr_word     = wr_addr_i[31:2];
  assign wr_in_range = ({2'b00, wr_word} < DEPTH_U);

`ifdef INST_MEM_ALIGN_CHECK_EN
  logic [1:0] unused_wr_low_bits;
  assign unused_wr_low_bits = wr_addr_i[1:0];
  assign rd_err = !rd_in_range || (rd_addr[1:0] != 2'b00);
`else
  logic [3:0] unused_low_bits;
  assign unused_low_bits = {rd_addr[1:0], wr_addr_i[1:0]};
  assign rd_err = !rd_in_range;
`endif

  assign load_resp = ((state_reg == ST_IDLE) && req_valid_i && NO_WAIT) ||
                     ((state_reg == ST_WAIT) && (wait_cnt_reg == 4'd0));

  assign req_ready_o  = (state_reg == ST_IDLE) && !rst;
  assign resp_valid_o = (state_reg == ST_RESP);
  assign resp_inst_o  = resp_inst_reg;
  assign resp_err_o   = resp_err_reg;

  // Program-load port; the array is never reset and loads are suppressed during reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_en_i && wr_in_range) begin
      mem[wr_word[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= 4'd0;
      addr_reg      <= 32'd0;
      resp_inst_reg <= 32'd0;
      resp_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid_i) begin
            addr_reg <= req_addr_i;
            if (NO_WAIT) begin
              state_reg <= ST_RESP;
            end else begin
              state_reg    <= ST_WAIT;
              wait_cnt_reg <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt_reg == 4'd0) begin
            state_reg <= ST_RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      // Faulting fetches never touch the array; a same-edge write lands after this read.
      if (load_resp) begin
        if (rd_err) begin
          resp_inst_reg <= NOP_INST;
          resp_err_reg  <= 1'b1;
        end else begin
          resp_inst_reg <= mem[rd_word[AW-1:0]];
          resp_err_reg  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_mem.sv
// Self-checking bench for inst_mem: directed scenarios plus randomized fetches
// checked against an array model of the instruction store.
module tb_inst_mem;

  localparam int          DEPTH = 256;
  localparam int          W     = 1;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_inst;
  logic        resp_err;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = 32'd0;
  logic [31:0] wr_data = 32'd0;

  logic [31:0] model_mem [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_mem #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_inst_o(resp_inst), .resp_err_o(resp_err),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
  );

  // Reference: {err, inst} a fetch of byte address a must return.
  function automatic logic [32:0] model_fetch(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 2;
`ifdef INST_MEM_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) return {1'b1, NOP};
`endif
    if (idx >= 32'(DEPTH)) return {1'b1, NOP};
    return {1'b0, model_mem[idx]};
  endfunction

  task automatic write_word(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] idx;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    idx = a >> 2;
    if (idx < 32'(DEPTH)) model_mem[idx] = d;
  endtask

  // Issues one fetch, holds resp_ready low for `hold` RESP cycles, then completes it.
  task automatic do_fetch(input logic [31:0] a, input int hold,
                          output logic [31:0] inst, output logic err, output int lat,
                          output bit stable, output bit post_ok);
    int guard;
    guard = 0;
    req_valid = 1'b1; req_addr = a;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 50) begin @(negedge clk); lat++; end
    inst = resp_inst; err = resp_err;
    stable = !req_ready;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!resp_valid || req_ready || resp_inst !== inst || resp_err !== err) stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    post_ok = !resp_valid && req_ready;
    $display("fetch addr=%h inst=%h err=%b lat=%0d hold=%0d", a, inst, err, lat, hold);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    n_checks++; if (resp_inst !== 32'd0) begin n_fail++; $display("FAIL reset_resp_inst: got %h expected 0", resp_inst); end
    n_checks++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL release_req_ready: got %b expected 1", req_ready); end
  endtask

  task automatic test_basic_fetch();
    logic [31:0] inst; logic err; int lat; bit st, po;
    for (int i = 0; i < DEPTH; i++) write_word(32'(i) << 2, $urandom);
    write_word(32'h0, 32'h00500093);
    do_fetch(32'h0, 0, inst, err, lat, st, po);
    n_checks++; if (inst !== 32'h00500093) begin n_fail++; $display("FAIL basic_inst: got %h expected 00500093", inst); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", err); end
    n_checks++; if (lat != W + 1) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, W + 1); end
    n_checks++; if (!po) begin n_fail++; $display("FAIL basic_return_idle: got valid=%b ready=%b expected 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] inst; logic err; int lat; bit st, po;
    logic [31:0] bad [2];
    bad[0] = 32'h00000400; bad[1] = 32'hFFFFFFFC;
    write_word(32'h00000400, 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) begin
      do_fetch(bad[i], 0, inst, err, lat, st, po);
      n_checks++; if (inst !== NOP || err !== 1'b1) begin n_fail++; $display("FAIL oor_resp %h: got %h/%b expected %h/1", bad[i], inst, err, NOP); end
      n_checks++; if (lat != W + 1) begin n_fail++; $display("FAIL oor_latency: got %0d expected %0d", lat, W + 1); end
    end
    do_fetch(32'h0, 0, inst, err, lat, st, po);
    n_checks++; if (inst !== 32'h00500093) begin n_fail++; $display("FAIL oor_write_alias: got %h expected 00500093", inst); end
  endtask

  task automatic test_hold();
    logic [31:0] inst; logic err; int lat; bit st, po;
    logic [32:0] exp;
    exp = model_fetch(32'h8);
    do_fetch(32'h8, 5, inst, err, lat, st, po);
    n_checks++; if (inst !== exp[31:0]) begin n_fail++; $display("FAIL hold_inst: got %h expected %h", inst, exp[31:0]); end
    n_checks++; if (!st) begin n_fail++; $display("FAIL hold_stable: got unstable outputs expected stable with req_ready 0"); end
    n_checks++; if (!po) begin n_fail++; $display("FAIL hold_release: got valid=%b ready=%b expected 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_read_before_write();
    logic [31:0] inst; logic err; int lat; bit st, po;
    write_word(32'h10, 32'h11111111);
    req_valid = 1'b1; req_addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (W - 1) @(negedge clk);
    wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'hAAAA0000;
    @(negedge clk);
    wr_en = 1'b0;
    model_mem[4] = 32'hAAAA0000;
    n_checks++; if (resp_valid !== 1'b1 || resp_inst !== 32'h11111111) begin n_fail++; $display("FAIL rbw_old_data: got %b/%h expected 1/11111111", resp_valid, resp_inst); end
    resp_ready = 1'b1; @(negedge clk); resp_ready = 1'b0;
    do_fetch(32'h10, 0, inst, err, lat, st, po);
    n_checks++; if (inst !== 32'hAAAA0000) begin n_fail++; $display("FAIL rbw_new_data: got %h expected AAAA0000", inst); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] inst; logic err; int lat; bit st, po; bit seen; int guard;
    logic [32:0] exp;
    req_valid = 1'b1; req_addr = 32'h20;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wait: got valid=%b ready=%b expected 0/0", resp_valid, req_ready); end
    wr_en = 1'b1; wr_addr = 32'h20; wr_data = ~model_mem[8];
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (resp_valid) seen = 1'b1; end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rst_abandon: got response after reset expected none"); end
    exp = model_fetch(32'h20);
    do_fetch(32'h20, 0, inst, err, lat, st, po);
    n_checks++; if (inst !== exp[31:0]) begin n_fail++; $display("FAIL rst_write_ignored: got %h expected %h", inst, exp[31:0]); end
    // Reset asserted between clock edges while a response is pending.
    req_valid = 1'b1; req_addr = 32'h24;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!resp_valid && guard < 50) begin @(negedge clk); guard++; end
    rst = 1'b1;
    #1;
    n_checks++; if (resp_valid !== 1'b0 || resp_inst !== 32'd0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_async_resp: got %b/%h/%b expected 0/0/0", resp_valid, resp_inst, resp_err); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_release: got ready=%b valid=%b expected 1/0", req_ready, resp_valid); end
  endtask

  task automatic test_misaligned();
    logic [31:0] inst; logic err; int lat; bit st, po;
    logic [32:0] exp;
    exp = model_fetch(32'h2);
    do_fetch(32'h2, 0, inst, err, lat, st, po);
    n_checks++; if (inst !== exp[31:0] || err !== exp[32]) begin n_fail++; $display("FAIL misaligned: got %h/%b expected %h/%b", inst, err, exp[31:0], exp[32]); end
    n_checks++; if (lat != W + 1) begin n_fail++; $display("FAIL misaligned_latency: got %0d expected %0d", lat, W + 1); end
  endtask

  task automatic test_random();
    logic [31:0] inst; logic err; int lat; bit st, po;
    logic [31:0] a; logic [32:0] exp; int hold; int kind;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6)      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (kind < 8) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else               a = 32'($urandom_range(DEPTH, 4096)) << 2;
      if ($urandom_range(0, 3) == 0) write_word(a & ~32'h3, $urandom);
      hold = $urandom_range(0, 3);
      exp = model_fetch(a);
      do_fetch(a, hold, inst, err, lat, st, po);
      n_checks++; if (inst !== exp[31:0]) begin n_fail++; $display("FAIL rand_inst %h: got %h expected %h", a, inst, exp[31:0]); end
      n_checks++; if (err !== exp[32]) begin n_fail++; $display("FAIL rand_err %h: got %b expected %b", a, err, exp[32]); end
      n_checks++; if (lat != W + 1) begin n_fail++; $display("FAIL rand_latency %h: got %0d expected %0d", a, lat, W + 1); end
      n_checks++; if (!st) begin n_fail++; $display("FAIL rand_stable %h: got unstable outputs expected stable", a); end
      n_checks++; if (!po) begin n_fail++; $display("FAIL rand_release %h: got no return to idle expected idle", a); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [6];
    logic [32:0] exp;
    int k, cyc, last;
    for (int i = 0; i < 6; i++) addrs[i] = 32'($urandom_range(0, DEPTH - 1)) << 2;
    k = 0; cyc = 0; last = -1;
    resp_ready = 1'b1; req_valid = 1'b1; req_addr = addrs[0];
    while (k < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) begin
        exp = model_fetch(addrs[k]);
        $display("b2b addr=%h inst=%h err=%b cycle=%0d", addrs[k], resp_inst, resp_err, cyc);
        n_checks++; if (resp_inst !== exp[31:0] || resp_err !== exp[32]) begin n_fail++; $display("FAIL b2b_resp %h: got %h/%b expected %h/%b", addrs[k], resp_inst, resp_err, exp[31:0], exp[32]); end
        if (last >= 0) begin
          n_checks++; if (cyc - last != W + 2) begin n_fail++; $display("FAIL b2b_interval: got %0d expected %0d", cyc - last, W + 2); end
        end
        last = cyc;
        k++;
        if (k < 6) req_addr = addrs[k];
        else req_valid = 1'b0;
      end
    end
    n_checks++; if (k != 6) begin n_fail++; $display("FAIL b2b_timeout: got %0d responses expected 6", k); end
    req_valid = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_out_of_range();
    test_hold();
    test_read_before_write();
    test_reset_mid();
    test_misaligned();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
